// File: rtl/systolic_feeder.sv
// Purpose : buffers one A tile (by column) and one W tile (by row) and replays
//           them as diagonally skewed operand streams into a ROW_A x COL_W array.
// Latency : start sampled at edge 0 -> CLEAR cycle 1, FEED 2..F+1, DRAIN PE_LAT,
//           DONE 1 cycle, DELOAD COL_W cycles with done on the last.
// Backpressure: none; runs to completion once started. start and tile writes are
//           dropped while busy.
// Ports   : clk, reset (async active-low); a_wr_*/w_wr_* tile write ports;
//           start; a_in/w_in skewed streams; reset_sys, compute_done, deload_out
//           array controls; busy, done run status. All outputs are registered.
module systolic_feeder #(
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ROW_A        = 4,
   parameter int COL_W        = 4,
   parameter int K_DIM        = 4,
   parameter int PE_LAT       = 1
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          a_wr_en,
   input  logic [$clog2(K_DIM > 1 ? K_DIM : 2)-1:0]      a_wr_addr,
   input  logic [DATA_WIDTH*ROW_A-1:0]                   a_wr_data,
   input  logic                                          w_wr_en,
   input  logic [$clog2(K_DIM > 1 ? K_DIM : 2)-1:0]      w_wr_addr,
   input  logic [WEIGHT_WIDTH*COL_W-1:0]                 w_wr_data,
   input  logic                                          start,
   output logic [DATA_WIDTH*ROW_A-1:0]                   a_in,
   output logic [WEIGHT_WIDTH*COL_W-1:0]                 w_in,
   output logic                                          reset_sys,
   output logic                                          compute_done,
   output logic                                          deload_out,
   output logic                                          busy,
   output logic                                          done
);

   localparam int F  = K_DIM + ROW_A + COL_W - 2;
   localparam int AW = $clog2(K_DIM > 1 ? K_DIM : 2);
   // One counter serves FEED, DRAIN and DELOAD; it must also be wide enough to
   // hold every lane index and K_DIM so the skew compares never wrap.
   localparam int CW = $clog2(F + PE_LAT + COL_W + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE, DELOAD} state_t;

   state_t                          state, nxt_st;
   logic [CW-1:0]                   cnt, nxt_cnt;
   logic [DATA_WIDTH*ROW_A-1:0]     a_buf [K_DIM];   // a_buf[k] = column k of A
   logic [WEIGHT_WIDTH*COL_W-1:0]   w_buf [K_DIM];   // w_buf[k] = row k of W
   logic [DATA_WIDTH*ROW_A-1:0]     a_nxt;
   logic [WEIGHT_WIDTH*COL_W-1:0]   w_nxt;

   // Tile buffers: written only while idle, cleared by reset, otherwise kept
   // across runs so a repeated start recomputes the same tile.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < K_DIM; k++) begin
            a_buf[k] <= '0;
            w_buf[k] <= '0;
         end
      end else if (!busy) begin
         for (int k = 0; k < K_DIM; k++) begin
            if (a_wr_en && a_wr_addr == AW'(k)) a_buf[k] <= a_wr_data;
            if (w_wr_en && w_wr_addr == AW'(k)) w_buf[k] <= w_wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt_st;
         cnt   <= nxt_cnt;
      end
   end

   always_comb begin
      nxt_st  = state;
      nxt_cnt = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               nxt_st  = CLEAR;
               nxt_cnt = '0;
            end
         end
         CLEAR: begin
            nxt_st  = FEED;
            nxt_cnt = '0;
         end
         FEED: begin
            if (cnt == CW'(F - 1)) begin
               nxt_st  = (PE_LAT > 0) ? DRAIN : DONE;
               nxt_cnt = '0;
            end else begin
               nxt_cnt = cnt + CW'(1);
            end
         end
         DRAIN: begin
            if (cnt == CW'(PE_LAT - 1)) begin
               nxt_st  = DONE;
               nxt_cnt = '0;
            end else begin
               nxt_cnt = cnt + CW'(1);
            end
         end
         DONE: begin
            nxt_st  = DELOAD;
            nxt_cnt = '0;
         end
         DELOAD: begin
            if (cnt == CW'(COL_W - 1)) begin
               nxt_st  = IDLE;
               nxt_cnt = '0;
            end else begin
               nxt_cnt = cnt + CW'(1);
            end
         end
         default: begin
            nxt_st  = IDLE;
            nxt_cnt = '0;
         end
      endcase
   end

   // Skewed operands for the cycle being entered. Lane j lags the wavefront by
   // j cycles; the >= test guards the unsigned subtraction against wrap-around.
   always_comb begin
      a_nxt = '0;
      w_nxt = '0;
      if (nxt_st == FEED) begin
         for (int j = 0; j < ROW_A; j++) begin
            if (nxt_cnt >= CW'(j) && (nxt_cnt - CW'(j)) < CW'(K_DIM))
               a_nxt[j*DATA_WIDTH +: DATA_WIDTH] =
                  a_buf[AW'(nxt_cnt - CW'(j))][j*DATA_WIDTH +: DATA_WIDTH];
         end
         for (int c = 0; c < COL_W; c++) begin
            if (nxt_cnt >= CW'(c) && (nxt_cnt - CW'(c)) < CW'(K_DIM))
               w_nxt[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                  w_buf[AW'(nxt_cnt - CW'(c))][c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_in         <= '0;
         w_in         <= '0;
         reset_sys    <= 1'b0;
         compute_done <= 1'b0;
         deload_out   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         a_in         <= a_nxt;
         w_in         <= w_nxt;
         reset_sys    <= (nxt_st == CLEAR);
         compute_done <= (nxt_st == DONE);
         deload_out   <= (nxt_st == DELOAD);
         busy         <= (nxt_st != IDLE);
         done         <= (nxt_st == DELOAD) && (nxt_cnt == CW'(COL_W - 1));
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

   localparam int DW   = 8;
   localparam int RA   = 4;
   localparam int CL   = 4;
   localparam int K    = 4;
   localparam int PL   = 1;
   localparam int F    = K + RA + CL - 2;
   localparam int RUNL = 2 + F + PL + CL;   // busy cycles per run
   localparam int AW   = $clog2(K);
   localparam int HMAX = 24;

   typedef struct packed {
      logic [DW*RA-1:0] a;
      logic [DW*CL-1:0] w;
      logic             reset_sys;
      logic             compute_done;
      logic             deload_out;
      logic             busy;
      logic             done;
   } out_t;

   logic                clk;
   logic                reset;
   logic                a_wr_en, w_wr_en, start;
   logic [AW-1:0]       a_wr_addr, w_wr_addr;
   logic [DW*RA-1:0]    a_wr_data;
   logic [DW*CL-1:0]    w_wr_data;
   logic [DW*RA-1:0]    a_in;
   logic [DW*CL-1:0]    w_in;
   logic                reset_sys, compute_done, deload_out, busy, done;

   systolic_feeder dut (
      .clk(clk), .reset(reset),
      .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
      .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
      .start(start), .a_in(a_in), .w_in(w_in), .reset_sys(reset_sys),
      .compute_done(compute_done), .deload_out(deload_out),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   compared   = 0;
   int   mismatched = 0;
   out_t exp_q [$];
   int   mA [RA][K];
   int   mW [K][CL];
   int   ha [HMAX][RA];
   int   hw [HMAX][CL];
   int   fidx = 0;

   function automatic out_t cur_out();
      out_t o;
      o.a = a_in; o.w = w_in; o.reset_sys = reset_sys;
      o.compute_done = compute_done; o.deload_out = deload_out;
      o.busy = busy; o.done = done;
      return o;
   endfunction

   // Expected outputs for cycle n (1-based) of a run started at edge 0.
   function automatic out_t exp_at(int n);
      out_t e;
      int   t;
      e = '0;
      e.busy = 1'b1;
      if (n == 1) e.reset_sys = 1'b1;
      if (n >= 2 && n < 2 + F) begin
         t = n - 2;
         for (int j = 0; j < RA; j++)
            if (t - j >= 0 && t - j < K) e.a[j*DW +: DW] = DW'(mA[j][t-j]);
         for (int c = 0; c < CL; c++)
            if (t - c >= 0 && t - c < K) e.w[c*DW +: DW] = DW'(mW[t-c][c]);
      end
      if (n == 2 + F + PL) e.compute_done = 1'b1;
      if (n > 2 + F + PL) e.deload_out = 1'b1;
      if (n == RUNL) e.done = 1'b1;
      return e;
   endfunction

   // Output-stationary PE (j,c) sees lane j delayed by c and lane c delayed by j.
   function automatic int pe_result(int j, int c);
      int acc = 0;
      for (int s = 0; s < HMAX; s++)
         if (s - c >= 0 && s - c < fidx && s - j >= 0 && s - j < fidx)
            acc += ha[s-c][j] * hw[s-j][c];
      return acc;
   endfunction

   function automatic int matmul(int j, int c);
      int acc = 0;
      for (int k = 0; k < K; k++) acc += mA[j][k] * mW[k][c];
      return acc;
   endfunction

   task automatic chk_out(string nm, out_t got, out_t exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic chk_int(string nm, int got, int exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d required %0d", nm, got, exp);
      end
   endtask

   // Monitor: pops one expectation whenever the DUT presents a busy/active cycle.
   always @(negedge clk) begin
      out_t got;
      got = cur_out();
      if (got.busy || got != '0) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_output: got %h required all zero", got);
         end else begin
            chk_out("run_cycle", got, exp_q.pop_front());
         end
      end
      if (reset_sys) begin
         fidx = 0;
      end else if (busy && fidx < HMAX) begin
         for (int j = 0; j < RA; j++) ha[fidx][j] = int'(a_in[j*DW +: DW]);
         for (int c = 0; c < CL; c++) hw[fidx][c] = int'(w_in[c*DW +: DW]);
         fidx++;
      end
      if (compute_done)
         for (int j = 0; j < RA; j++)
            for (int c = 0; c < CL; c++)
               chk_int($sformatf("pe_result[%0d][%0d]", j, c), pe_result(j, c), matmul(j, c));
   end

   task automatic load_tiles();
      for (int k = 0; k < K; k++) begin
         a_wr_en = 1'b1; a_wr_addr = AW'(k);
         w_wr_en = 1'b1; w_wr_addr = AW'(k);
         for (int j = 0; j < RA; j++) a_wr_data[j*DW +: DW] = DW'(mA[j][k]);
         for (int c = 0; c < CL; c++) w_wr_data[c*DW +: DW] = DW'(mW[k][c]);
         @(posedge clk); #1;
      end
      a_wr_en = 1'b0;
      w_wr_en = 1'b0;
   endtask

   // Starts a run in the current cycle. inject drives ignored start/write
   // traffic mid-run; abort_at asserts reset during that cycle.
   task automatic run(input bit inject, input bit skewchk, input int abort_at);
      start = 1'b1;
      for (int n = 1; n <= RUNL; n++) exp_q.push_back(exp_at(n));
      for (int n = 1; n <= RUNL; n++) begin
         @(posedge clk); #1;
         start   = 1'b0;
         a_wr_en = 1'b0;
         if (inject && (n == 5 || n == 13)) start = 1'b1;
         if (inject && n == 6) begin
            a_wr_en   = 1'b1;
            a_wr_addr = AW'($urandom_range(K - 1));
            a_wr_data = DW*RA'($urandom);
         end
         if (skewchk && n == 5) begin
            chk_int("skew_a_t3", int'(a_in), int'(32'h30211203));
            chk_int("skew_w_t3", int'(w_in), int'(32'h03122130));
         end
         if (n == abort_at) begin
            reset = 1'b0;
            #1;
            chk_out("abort_outputs", cur_out(), '0);
            exp_q.delete();
            for (int j = 0; j < RA; j++) for (int k = 0; k < K; k++) mA[j][k] = 0;
            for (int k = 0; k < K; k++) for (int c = 0; c < CL; c++) mW[k][c] = 0;
            return;
         end
      end
      @(posedge clk); #1;
      start   = 1'b0;
      a_wr_en = 1'b0;
      chk_int("idle_after_run", int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0;
      a_wr_en = 1'b0; w_wr_en = 1'b0;
      a_wr_addr = '0; w_wr_addr = '0; a_wr_data = '0; w_wr_data = '0;
      for (int j = 0; j < RA; j++) for (int k = 0; k < K; k++) mA[j][k] = 0;
      for (int k = 0; k < K; k++) for (int c = 0; c < CL; c++) mW[k][c] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset_state", cur_out(), '0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Skew pattern with recognisable element values.
      for (int j = 0; j < RA; j++) for (int k = 0; k < K; k++) mA[j][k] = 16*j + k;
      for (int k = 0; k < K; k++) for (int c = 0; c < CL; c++) mW[k][c] = 16*k + c;
      load_tiles();
      run(1'b0, 1'b1, 0);

      // Random tiles.
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < RA; j++) for (int k = 0; k < K; k++) mA[j][k] = $urandom_range(255);
         for (int k = 0; k < K; k++) for (int c = 0; c < CL; c++) mW[k][c] = $urandom_range(255);
         load_tiles();
         run(1'b0, 1'b0, 0);
      end

      // Identity weights with ignored start/write traffic, then a back-to-back
      // rerun that must reproduce the same tile.
      for (int j = 0; j < RA; j++) for (int k = 0; k < K; k++) mA[j][k] = 4*j + k + 1;
      for (int k = 0; k < K; k++) for (int c = 0; c < CL; c++) mW[k][c] = (k == c) ? 1 : 0;
      load_tiles();
      run(1'b1, 1'b0, 0);
      run(1'b0, 1'b0, 0);
      for (int j = 0; j < RA; j++)
         for (int c = 0; c < CL; c++)
            chk_int("identity_model", matmul(j, c), 4*j + c + 1);

      // Abort mid-FEED, then a fresh run from the cleared buffers.
      run(1'b0, 1'b0, 8);
      repeat (2) @(posedge clk);
      #1;
      chk_out("held_in_reset", cur_out(), '0);
      reset = 1'b1;
      @(posedge clk); #1;
      run(1'b0, 1'b0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk_int("expect_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
